// File: rtl/bcd_timer_ctrl_if.sv
// Host-side command/status bundle for the mod-60 BCD timer controller.
//   master : host / front panel (drives commands, observes status)
//   slave  : bcd_timer_ctrl (receives commands, drives status)
// Signals:
//   start, stop, clear, load : single-cycle command pulses
//   load_value[7:0]          : BCD preset {tens,units}
//   mode                     : 1=up, 0=down, sampled on an accepted start
//   count[7:0]               : current BCD value {tens,units}
//   running, done            : state indications
//   tick, load_err           : one-cycle strobes
interface bcd_timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       mode;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       tick;
  logic       load_err;

  modport master (
    output start, stop, clear, load, load_value, mode,
    input  count, running, done, tick, load_err
  );

  modport slave (
    input  start, stop, clear, load, load_value, mode,
    output count, running, done, tick, load_err
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a 2-digit mod-60 BCD counter (stopwatch / countdown).
// Owns the count register, a tick prescaler, a BCD reload register and an
// IDLE/RUN/PAUSE/DONE state machine. All state changes on the falling clock edge.
// Ports:
//   clock  : clock, falling-edge active
//   reset  : asynchronous, active-low reset
//   bus    : bcd_timer_ctrl_if.slave (commands in; count/running/done/tick/load_err out)
// Parameters:
//   PRESCALE : clocks per count tick (>= 2)
//   MAX_BCD  : terminal value in up mode (valid 2-digit BCD)
// Build option:
//   BCD_TIMER_AUTORELOAD_EN : when defined, reaching terminal in RUN reloads the
//   count from the reload register and keeps running (done pulses for one cycle);
//   when undefined, DONE is a sticky state left only by start, load or clear.
module bcd_timer_ctrl #(
  parameter int unsigned PRESCALE = 50,
  parameter logic [7:0]  MAX_BCD  = 8'h59
) (
  input logic             clock,
  input logic             reset,
  bcd_timer_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    reload_q, reload_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mode_q, mode_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;
  logic          load_err_q, load_err_d;

  logic          load_ok;
  logic          advance;
  logic          done_pulse;
  logic [7:0]    step_val;

  // BCD increment with units carry into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] < 4'd9) r = {v[7:4], v[3:0] + 4'd1};
    else               r = {v[7:4] + 4'd1, 4'd0};
    return r;
  endfunction

  // BCD decrement with units borrow from tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) r = {v[7:4], v[3:0] - 4'd1};
    else                r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  // Terminal value for the given direction.
  function automatic logic at_terminal(input logic [7:0] v, input logic up);
    return up ? (v == MAX_BCD) : (v == 8'h00);
  endfunction

  // A preset is accepted only if both digits are decimal and it is in range.
  assign load_ok = (bus.load_value[7:4] <= 4'd9) &&
                   (bus.load_value[3:0] <= 4'd9) &&
                   (bus.load_value <= MAX_BCD);

  // State register and all registered outputs.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 8'h00;
      reload_q   <= 8'h00;
      pre_q      <= '0;
      mode_q     <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      pre_q      <= pre_d;
      mode_q     <= mode_d;
      running_q  <= running_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  // Next-state / output logic. Only the highest-priority command is acted on;
  // RUN keeps counting unless the winning command takes it out of RUN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    pre_d      = pre_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    load_err_d = 1'b0;
    done_pulse = 1'b0;
    advance    = 1'b0;
    step_val   = mode_q ? bcd_inc(count_q) : bcd_dec(count_q);

    if (bus.clear) begin
      count_d = 8'h00;
      pre_d   = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      if (state_q == RUN) begin
        load_err_d = 1'b1;
        advance    = 1'b1;
      end else if (!load_ok) begin
        load_err_d = 1'b1;
      end else begin
        count_d  = bus.load_value;
        reload_d = bus.load_value;
        if (state_q == DONE) state_d = IDLE;
      end
    end else if (bus.stop) begin
      // Stop beats a coincident tick: prescaler and count hold.
      if (state_q == RUN) state_d = PAUSE;
    end else if (bus.start) begin
      case (state_q)
        IDLE, PAUSE: begin
          mode_d  = bus.mode;
          pre_d   = '0;
          state_d = at_terminal(count_q, bus.mode) ? DONE : RUN;
        end
        DONE: begin
          count_d = reload_q;
          mode_d  = bus.mode;
          pre_d   = '0;
          // A reload already at terminal would count past the end; stay done.
          state_d = at_terminal(reload_q, bus.mode) ? DONE : RUN;
        end
        default: advance = 1'b1;
      endcase
    end else begin
      advance = (state_q == RUN);
    end

    // Prescaler and count update while running.
    if (advance) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (at_terminal(step_val, mode_q)) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
          if (at_terminal(reload_q, mode_q)) begin
            count_d = step_val;
            state_d = DONE;
          end else begin
            count_d    = reload_q;
            done_pulse = 1'b1;
          end
`else
          count_d = step_val;
          state_d = DONE;
`endif
        end else begin
          count_d = step_val;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE) || done_pulse;
  end

  assign bus.count    = count_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.tick     = tick_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl (PRESCALE=4, MAX_BCD=8'h59).
// A decimal-valued behavioural model tracks the expected outputs; a compare
// process checks every output on each rising edge (mid-cycle for the
// falling-edge design). Directed scenarios add literal expectations, then a
// randomized command phase runs against the model.
module tb_bcd_timer_ctrl;

  localparam int P   = 4;
  localparam int TOP = 59;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcd_timer_ctrl_if bus();

  bcd_timer_ctrl #(.PRESCALE(P), .MAX_BCD(8'h59)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state: count kept as a plain decimal number
  int m_state, m_val, m_reload, m_pre;
  bit m_up, m_tick, m_err, m_dp;

  function automatic logic [7:0] bcd_of(input int v);
    logic [7:0] r;
    r = {4'(v / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic bit at_end(input int v, input bit up);
    return up ? (v == TOP) : (v == 0);
  endfunction

  function automatic bit preset_ok(input logic [7:0] lv);
    int hi, lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= TOP);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference, evaluated on the design's active edge.
  always @(negedge clock or negedge reset) begin : model_b
    int  st, v, rl, pre;
    bit  up, tk, er, dp, adv;
    if (!reset) begin
      m_state  <= S_IDLE;
      m_val    <= 0;
      m_reload <= 0;
      m_pre    <= 0;
      m_up     <= 1'b0;
      m_tick   <= 1'b0;
      m_err    <= 1'b0;
      m_dp     <= 1'b0;
    end else begin
      st = m_state; v = m_val; rl = m_reload; pre = m_pre; up = m_up;
      tk = 1'b0; er = 1'b0; dp = 1'b0; adv = 1'b0;
      if (bus.clear) begin
        v = 0; pre = 0; st = S_IDLE;
      end else if (bus.load) begin
        if (st == S_RUN) begin
          er = 1'b1; adv = 1'b1;
        end else if (!preset_ok(bus.load_value)) begin
          er = 1'b1;
        end else begin
          v  = int'(bus.load_value[7:4]) * 10 + int'(bus.load_value[3:0]);
          rl = v;
          if (st == S_DONE) st = S_IDLE;
        end
      end else if (bus.stop) begin
        if (st == S_RUN) st = S_PAUSE;
      end else if (bus.start) begin
        if (st == S_RUN) adv = 1'b1;
        else begin
          if (st == S_DONE) v = rl;
          up  = bus.mode;
          pre = 0;
          st  = at_end(v, up) ? S_DONE : S_RUN;
        end
      end else begin
        adv = (st == S_RUN);
      end
      if (adv) begin
        pre = pre + 1;
        if (pre == P) begin
          pre = 0;
          tk  = 1'b1;
          v   = up ? v + 1 : v - 1;
          if (at_end(v, up)) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (at_end(rl, up)) st = S_DONE;
            else begin
              v  = rl;
              dp = 1'b1;
            end
`else
            st = S_DONE;
`endif
          end
        end
      end
      m_state  <= st;
      m_val    <= v;
      m_reload <= rl;
      m_pre    <= pre;
      m_up     <= up;
      m_tick   <= tk;
      m_err    <= er;
      m_dp     <= dp;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clock) begin
    if (chk_en) begin
      chk("count",    bus.count,          bcd_of(m_val));
      chk("running",  8'(bus.running),    8'(m_state == S_RUN));
      chk("done",     8'(bus.done),       8'((m_state == S_DONE) || m_dp));
      chk("tick",     8'(bus.tick),       8'(m_tick));
      chk("load_err", 8'(bus.load_err),   8'(m_err));
    end
  end

  // One command cycle: inputs change just after the rising edge, the design
  // consumes them on the following falling edge.
  task automatic drive(input bit s, input bit p, input bit c, input bit l,
                       input logic [7:0] lv, input bit m);
    @(posedge clock);
    #1;
    bus.start = s; bus.stop = p; bus.clear = c; bus.load = l;
    bus.load_value = lv; bus.mode = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_value = 8'h00; bus.mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    chk("rst_count", bus.count, 8'h00);
    chk("rst_flags", {4'b0, bus.running, bus.done, bus.tick, bus.load_err}, 8'h00);
    reset = 1'b1;

    // up count 57 -> 58 -> 59, done
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h57, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    chk("up_start_cnt", bus.count, 8'h57);
    chk("up_start_run", 8'(bus.running), 8'd1);
    idle(4);
    chk("up_tick1_cnt", bus.count, 8'h58);
    chk("up_tick1_tk",  8'(bus.tick), 8'd1);
    idle(4);
    chk("up_end_cnt",  bus.count, 8'h59);
    chk("up_end_done", {bus.running, bus.done}, 8'h01);
    idle(3);
    chk("up_hold_cnt", bus.count, 8'h59);

    // down count 10 -> 09 (borrow) ... 00
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("dn_borrow", bus.count, 8'h09);
    idle(36);
    chk("dn_end_done", 8'(bus.done), 8'd1);
`ifdef BCD_TIMER_AUTORELOAD_EN
    chk("dn_end_cnt", bus.count, 8'h10);
    idle(1);
    chk("dn_pulse_off", {bus.running, bus.done}, 8'h02);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
`else
    chk("dn_end_cnt", bus.count, 8'h00);
    idle(1);
    chk("dn_sticky", {bus.running, bus.done}, 8'h01);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("restart_cnt", bus.count, 8'h10);
    chk("restart_run", 8'(bus.running), 8'd1);

    // rejected loads: in RUN, then non-BCD and out of range in PAUSE
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    idle(1);
    chk("ld_run_err", {bus.running, bus.load_err}, 8'h03);
    chk("ld_run_cnt", bus.count, 8'h10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    idle(1);
    chk("ld_5a_err", {bus.running, bus.load_err}, 8'h01);
    chk("ld_5a_cnt", bus.count, 8'h10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h60, 1'b0);
    idle(1);
    chk("ld_60_err", 8'(bus.load_err), 8'd1);
    chk("ld_60_cnt", bus.count, 8'h10);

    // stop on the tick edge wins
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("stop_tick", {bus.running, bus.tick}, 8'h00);
    chk("stop_cnt",  bus.count, 8'h10);
    // clear + load + start together: clear wins
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    idle(1);
    chk("clr_all_cnt", bus.count, 8'h00);
    chk("clr_all_st",  {bus.running, bus.done}, 8'h00);
    // start down at 00: straight to DONE, no tick
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1);
    chk("term_start", {bus.running, bus.done, bus.tick}, 8'h02);

    // 02 down: 01, then terminal
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(5);
    chk("ar_first", bus.count, 8'h01);
    idle(4);
`ifdef BCD_TIMER_AUTORELOAD_EN
    chk("ar_cnt",   bus.count, 8'h02);
    chk("ar_flags", {bus.running, bus.done, bus.tick}, 8'h07);
    idle(1);
    chk("ar_after", {bus.running, bus.done}, 8'h02);
`else
    chk("ar_cnt",   bus.count, 8'h00);
    chk("ar_flags", {bus.running, bus.done, bus.tick}, 8'h03);
    idle(1);
    chk("ar_after", {bus.running, bus.done}, 8'h01);
`endif

    // asynchronous reset mid-run, held with start asserted
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(6);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_cnt",   bus.count, 8'h00);
    chk("arst_flags", {bus.running, bus.done, bus.tick}, 8'h00);
    bus.start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("arst_hold", {bus.count[6:0], bus.running}, 8'h00);
    bus.start = 1'b0;
    reset = 1'b1;

    // randomized command phase
    for (int i = 0; i < 4000; i++) begin
      bit s, p, c, l, m;
      logic [7:0] lv;
      if ($urandom_range(0, 999) < 2) begin
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
      end
      s  = ($urandom_range(0, 99) < 8);
      p  = ($urandom_range(0, 99) < 4);
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 7);
      m  = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 1) == 0) ? bcd_of(int'($urandom_range(0, 59)))
                                       : 8'($urandom);
      drive(s, p, c, l, lv, m);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
